// File: rtl/dsp_pkg.sv
// Shared definitions for the accumulator/ALU datapath: opcodes, FSM encoding,
// and the default datapath width.
package dsp_pkg;

    localparam int DSP_WIDTH = 8;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MUL_ITER = 2'd2
    } state_t;

endpackage

// File: rtl/add_cin.sv
// WIDTH-bit ripple adder with carry-in and carry-out; shared by ADD, SUB
// and the multiply partial-sum step.
module add_cin #(
    parameter int WIDTH = dsp_pkg::DSP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/acc_alu_stage.sv
// Registered accumulator/ALU stage with valid/ready input, one-cycle Done
// pulse and Carry/Zero/Neg/Ovf status flags.
module acc_alu_stage
    import dsp_pkg::*;
#(
    parameter int WIDTH  = DSP_WIDTH,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] Operand,
    input  logic [WIDTH-1:0] Operand_n,
    output logic [WIDTH-1:0] Acc_out,
    output logic             Carry,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf,
    output logic             Done
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg, op_next;
    logic [WIDTH-1:0]   opb_reg, opb_next;
    logic [WIDTH-1:0]   opbn_reg, opbn_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic               carry_reg, carry_next;
    logic               ovf_reg, ovf_next;
    logic               done_reg, done_next;
    logic [2*WIDTH-1:0] prod_reg, prod_next;
    logic [CW-1:0]      cnt_reg, cnt_next;

    logic [WIDTH-1:0]   add_a, add_b, add_sum;
    logic               add_ci, add_co;
    logic [2*WIDTH-1:0] mul_step;

    add_cin #(.WIDTH(WIDTH)) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_ci),
        .sum  (add_sum),
        .cout (add_co)
    );

    // Adder operand steering: SUB adds the pre-complemented operand plus one;
    // multiply adds the multiplicand into the product high half.
    always_comb begin
        add_a  = acc_reg;
        add_b  = opb_reg;
        add_ci = 1'b0;
        if (state_reg == ST_MUL_ITER) begin
            add_a = prod_reg[2*WIDTH-1:WIDTH];
            add_b = prod_reg[0] ? acc_reg : '0;
        end else if (op_reg == OP_SUB) begin
            add_b  = opbn_reg;
            add_ci = 1'b1;
        end
    end

    // Product low half starts as the multiplier; its LSB selects each add,
    // then the whole register shifts right taking in the adder carry.
    assign mul_step = {add_co, add_sum, prod_reg[WIDTH-1:1]};

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        opb_next   = opb_reg;
        opbn_next  = opbn_reg;
        acc_next   = acc_reg;
        carry_next = carry_reg;
        ovf_next   = ovf_reg;
        done_next  = 1'b0;
        prod_next  = prod_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (In_valid) begin
                    op_next   = Op;
                    opb_next  = Operand;
                    opbn_next = Operand_n;
                    cnt_next  = '0;
                    if (Op == OP_MUL && MUL_EN) begin
                        prod_next  = {{WIDTH{1'b0}}, Operand};
                        state_next = ST_MUL_ITER;
                    end else begin
                        state_next = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                case (op_reg)
                    OP_LOAD: begin
                        acc_next   = opb_reg;
                        carry_next = 1'b0;
                        ovf_next   = 1'b0;
                    end
                    OP_ADD: begin
                        acc_next   = add_sum;
                        carry_next = add_co;
                        ovf_next   = (acc_reg[MSB] == opb_reg[MSB]) &&
                                     (add_sum[MSB] != acc_reg[MSB]);
                    end
                    OP_SUB: begin
                        acc_next   = add_sum;
                        carry_next = add_co;
                        ovf_next   = (acc_reg[MSB] != opb_reg[MSB]) &&
                                     (add_sum[MSB] != acc_reg[MSB]);
                    end
                    OP_CLR: begin
                        acc_next   = '0;
                        carry_next = 1'b0;
                        ovf_next   = 1'b0;
                    end
                    default: begin
                    end
                endcase
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end

            ST_MUL_ITER: begin
                prod_next = mul_step;
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    acc_next   = mul_step[WIDTH-1:0];
                    carry_next = |mul_step[2*WIDTH-1:WIDTH];
                    ovf_next   = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_NOP;
            opb_reg   <= '0;
            opbn_reg  <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
            prod_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            opb_reg   <= opb_next;
            opbn_reg  <= opbn_next;
            acc_reg   <= acc_next;
            carry_reg <= carry_next;
            ovf_reg   <= ovf_next;
            done_reg  <= done_next;
            prod_reg  <= prod_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign In_ready = (state_reg == ST_IDLE);
    assign Acc_out  = acc_reg;
    assign Carry    = carry_reg;
    assign Zero     = (acc_reg == '0);
    assign Neg      = acc_reg[MSB];
    assign Ovf      = ovf_reg;
    assign Done     = done_reg;

endmodule

// File: tb/tb_acc_alu_stage.sv
// Bench for acc_alu_stage: directed vector table, reset/back-to-back
// sequences and random ops checked against an arithmetic reference model.
module tb_acc_alu_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       In_valid;
    logic       In_ready;
    logic [2:0] Op;
    logic [7:0] Operand;
    logic [7:0] Operand_n;
    logic [7:0] Acc_out;
    logic       Carry, Zero, Neg, Ovf, Done;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_acc;
    logic       m_c, m_o;

    typedef struct {
        logic [2:0] op;
        logic [7:0] b;
        logic [7:0] acc;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs[16];

    acc_alu_stage #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Op        (Op),
        .Operand   (Operand),
        .Operand_n (Operand_n),
        .Acc_out   (Acc_out),
        .Carry     (Carry),
        .Zero      (Zero),
        .Neg       (Neg),
        .Ovf       (Ovf),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural state.
    task automatic model_step(input logic [2:0] op, input logic [7:0] b);
        int r;
        case (op)
            3'd1: begin m_acc = b; m_c = 0; m_o = 0; end
            3'd2: begin
                r     = int'($signed(m_acc)) + int'($signed(b));
                m_o   = (r > 127) || (r < -128);
                m_c   = (int'(m_acc) + int'(b)) > 255;
                m_acc = m_acc + b;
            end
            3'd3: begin
                r     = int'($signed(m_acc)) - int'($signed(b));
                m_o   = (r > 127) || (r < -128);
                m_c   = m_acc >= b;
                m_acc = m_acc - b;
            end
            3'd4: begin
                r     = int'(m_acc) * int'(b);
                m_acc = r[7:0];
                m_c   = r > 255;
                m_o   = 0;
            end
            3'd5: begin m_acc = 0; m_c = 0; m_o = 0; end
            default: begin end
        endcase
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_acc"},   Acc_out, m_acc);
        chk({tag, "_carry"}, Carry,   m_c);
        chk({tag, "_ovf"},   Ovf,     m_o);
        chk({tag, "_zero"},  Zero,    m_acc == 8'h00);
        chk({tag, "_neg"},   Neg,     m_acc[7]);
    endtask

    // One request through the handshake; returns on the negedge after Done drops.
    task automatic do_op(input logic [2:0] op, input logic [7:0] b, input string tag);
        int n;
        int exp_lat;
        exp_lat = (op == 3'd4) ? 9 : 2;
        @(negedge clk);
        chk({tag, "_ready_idle"}, In_ready, 1);
        In_valid  = 1'b1;
        Op        = op;
        Operand   = b;
        Operand_n = ~b;
        @(negedge clk);
        In_valid = 1'b0;
        n = 1;
        while (n < 30 && Done !== 1'b1) begin
            chk({tag, "_busy_ready"}, In_ready, 0);
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, Done, 1);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_ready_with_done"}, In_ready, 1);
        model_step(op, b);
        check_flags(tag);
        $display("op=%0d b=%02h acc=%02h c=%0b z=%0b n=%0b v=%0b lat=%0d", op, b, Acc_out, Carry, Zero, Neg, Ovf, n);
        @(negedge clk);
        chk({tag, "_done_single"}, Done, 0);
    endtask

    initial begin
        int accepts, dones, cyc, done_cnt;
        logic [2:0] rop;
        logic [7:0] rb;

        vecs[0]  = '{3'd1, 8'h05, 8'h05, 1'b0, 1'b0};
        vecs[1]  = '{3'd2, 8'h03, 8'h08, 1'b0, 1'b0};
        vecs[2]  = '{3'd3, 8'h0A, 8'hFE, 1'b0, 1'b0};
        vecs[3]  = '{3'd1, 8'h7F, 8'h7F, 1'b0, 1'b0};
        vecs[4]  = '{3'd2, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[5]  = '{3'd1, 8'h80, 8'h80, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[7]  = '{3'd1, 8'h12, 8'h12, 1'b0, 1'b0};
        vecs[8]  = '{3'd4, 8'h0D, 8'hEA, 1'b0, 1'b0};
        vecs[9]  = '{3'd1, 8'h20, 8'h20, 1'b0, 1'b0};
        vecs[10] = '{3'd4, 8'h10, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{3'd0, 8'h55, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{3'd1, 8'h9C, 8'h9C, 1'b0, 1'b0};
        vecs[13] = '{3'd7, 8'h11, 8'h9C, 1'b0, 1'b0};
        vecs[14] = '{3'd5, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[15] = '{3'd6, 8'h42, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0; In_valid = 1'b0; Op = 3'd0; Operand = 8'h00; Operand_n = 8'hFF;
        m_acc = 0; m_c = 0; m_o = 0;
        #1;
        chk("rst_acc", Acc_out, 8'h00);
        chk("rst_zero", Zero, 1);
        chk("rst_flags", {Carry, Neg, Ovf, Done}, 4'b0000);
        chk("rst_ready", In_ready, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].b, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_acc", i),   Acc_out, vecs[i].acc);
            chk($sformatf("vec%0d_tbl_carry", i), Carry,   vecs[i].c);
            chk($sformatf("vec%0d_tbl_ovf", i),   Ovf,     vecs[i].o);
            chk($sformatf("vec%0d_tbl_zero", i),  Zero,    vecs[i].acc == 8'h00);
            chk($sformatf("vec%0d_tbl_neg", i),   Neg,     vecs[i].acc[7]);
        end

        // Reset three cycles into a multiply.
        do_op(3'd1, 8'h12, "pre_rst");
        @(negedge clk);
        In_valid = 1'b1; Op = 3'd4; Operand = 8'h0D; Operand_n = 8'hF2;
        @(posedge clk);
        #1 In_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_acc = 0; m_c = 0; m_o = 0;
        $display("async reset mid-mul: acc=%02h ready=%0b done=%0b", Acc_out, In_ready, Done);
        chk("midrst_acc", Acc_out, 8'h00);
        chk("midrst_zero", Zero, 1);
        chk("midrst_flags", {Carry, Neg, Ovf, Done}, 4'b0000);
        chk("midrst_ready", In_ready, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (Done) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_acc_held", Acc_out, 8'h00);
        do_op(3'd1, 8'h33, "post_rst");
        chk("post_rst_load", Acc_out, 8'h33);

        // Back-to-back ADD 1 with In_valid held high.
        do_op(3'd5, 8'h00, "b2b_clr");
        accepts = 0; dones = 0;
        @(negedge clk);
        In_valid = 1'b1; Op = 3'd2; Operand = 8'h01; Operand_n = 8'hFE;
        for (cyc = 0; cyc < 20; cyc++) begin
            if (Done) begin
                dones++;
                chk("b2b_acc", Acc_out, dones);
                chk("b2b_ready_with_done", In_ready, 1);
                $display("b2b done %0d acc=%02h", dones, Acc_out);
            end
            if (accepts == 4) In_valid = 1'b0;
            if (In_valid && In_ready) accepts++;
            @(negedge clk);
        end
        In_valid = 1'b0;
        chk("b2b_done_count", dones, 4);
        for (int k = 0; k < 4; k++) model_step(3'd2, 8'h01);
        check_flags("b2b_final");
        do_op(3'd7, 8'hAA, "b2b_resv");
        chk("b2b_resv_acc", Acc_out, 8'h04);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            rb  = 8'($urandom_range(0, 255));
            do_op(rop, rb, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", $time, 200000);
        $fatal(1, "timeout");
    end

endmodule
